vmac_int8_seq: RTL
==================

VMAC_INT8_SEQ -- requirements
Module: vmac_int8_seq

Interface
REQ-001 SHALL have parameter ACC_W, default 24, signed accumulator width (legal range 17..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_a input 8, in_b input 8, in_last input 1: operand-pair stream; in_a and in_b are signed int8; in_last marks the final pair of a vector.
REQ-005 SHALL have ports mul_start output 1, mul_a output 4, mul_b output 4: drive the downstream 4x4 unsigned shift-add multiplier.
REQ-006 SHALL have ports mul_o input 8, mul_finish input 1: multiplier product and its done flag, both from the multiplier's own self-timed domain.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, acc_out output ACC_W: signed dot-product result stream.

Function
REQ-008 SHALL pass mul_finish through a 2-flop synchronizer (fin_s) before any use.
REQ-009 SHALL use states IDLE, REQ, REL, ACC, OUT.
REQ-010 IDLE: in_ready=1; on in_valid&in_ready, latch |in_a| and |in_b| as 8-bit unsigned, sign=in_a[7]^in_b[7], last=in_last, clear prod[15:0], nibble index k=0, go to REQ.
REQ-011 |-128| SHALL be represented as unsigned 8'h80 with no overflow.
REQ-012 Nibble order k=0..3: (aL,bL) shift 0, (aL,bH) shift 4, (aH,bL) shift 4, (aH,bH) shift 8.
REQ-013 mul_a/mul_b SHALL be registered and stable one full cycle before mul_start rises and throughout REQ and REL.
REQ-014 REQ: mul_start=1; when fin_s=1, add (mul_o << shift(k)) into prod, go to REL.
REQ-015 REL: mul_start=0; when fin_s=0, k=k+1 and go to REQ, or go to ACC if k==3.
REQ-016 ACC (1 cycle): acc = acc + (sign ? -prod : prod), sign-extended to ACC_W; then OUT if last, else IDLE.
REQ-017 OUT: out_valid=1, acc_out=acc held stable until out_ready; on out_valid&out_ready clear acc to 0 and go to IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-019 Zero operands SHALL still perform all four nibble handshakes (no early exit).
REQ-020 Product range SHALL be -16256..+16384; prod is exact in 16 bits unsigned before signing.

Reset
REQ-021 On reset: state=IDLE, mul_start=0, mul_a=0, mul_b=0, in_ready=1 after release, out_valid=0, acc_out=0, acc=0, prod=0, synchronizer flops=0.
REQ-022 Reset mid-operation (any state) SHALL abort the pair and discard the partial vector; mul_start drops immediately (asynchronously).

Configuration
REQ-023 Macro VMAC_SAT_EN: when defined, ACC-state addition SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; when undefined, it SHALL wrap modulo 2^ACC_W.

Verification
REQ-024 Single pair 3*5, last=1 -> out_valid with acc_out=15; exactly four mul_start pulses observed.
REQ-025 Single pair -128*-128, last=1 -> acc_out=16384; 127*-128, last=1 -> acc_out=-16256.
REQ-026 Vector (1,2),(-3,4),(5,-6),(7,8), last on 4th -> acc_out=16; out_ready held low 5 cycles -> acc_out stable, in_ready=0 throughout.
REQ-027 521 pairs of 127*127, ACC_W=24 -> with VMAC_SAT_EN acc_out=8388607; without, acc_out=-8374007.
REQ-028 Assert reset while in REQ with mul_start=1 -> mul_start=0 same cycle, out_valid=0; after release, pair 2*2 last=1 -> acc_out=4.

Source files
------------

// File: rtl/vmac_int8_seq.sv
// vmac_int8_seq: signed int8 dot-product MAC over an external 4x4 nibble multiplier.
// Define VMAC_SAT_EN to saturate the accumulator instead of wrapping.
module vmac_int8_seq #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_o,
    input  logic             mul_finish,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        ACC,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic              fin_m;
    logic              fin_s;
    logic [7:0]        abs_a;
    logic [7:0]        abs_b;
    logic [7:0]        mag_a;
    logic [7:0]        mag_b;
    logic              sign;
    logic              last;
    logic [1:0]        k;
    logic [1:0]        k_nx;
    logic [15:0]       prod;
    logic [15:0]       part;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nx;
    logic signed [16:0] p17;
    logic signed [16:0] t17;
    logic [ACC_W-1:0]  term;
    logic [ACC_W:0]    sum;
    logic              accept;
    logic              got_fin;
    logic              step;
    logic              out_fire;

    // |-128| fits as 8'h80 because the magnitude is kept unsigned
    assign mag_a = in_a[7] ? (~in_a + 8'd1) : in_a;
    assign mag_b = in_b[7] ? (~in_b + 8'd1) : in_b;
    assign k_nx  = k + 2'd1;

    assign accept   = (state == IDLE) && in_valid;
    assign got_fin  = (state == REQ) && mul_start && fin_s;
    assign step     = (state == REL) && !fin_s && (k != 2'd3);
    assign out_fire = (state == OUT) && out_ready;
    assign acc_out  = acc;

    // bring the multiplier's done flag into our clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_m <= 1'b0;
            fin_s <= 1'b0;
        end else begin
            fin_m <= mul_finish;
            fin_s <= fin_m;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = REQ;
            end
            REQ: begin
                if (mul_start && fin_s) state_nx = REL;
            end
            REL: begin
                if (!fin_s) state_nx = (k == 2'd3) ? ACC : REQ;
            end
            ACC: begin
                state_nx = last ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // place the nibble product at its weight: k=0 -> 0, k=1,2 -> 4, k=3 -> 8
    always_comb begin
        part = {8'd0, mul_o};
        case (k)
            2'd0:    part = {8'd0, mul_o};
            2'd3:    part = {mul_o, 8'd0};
            default: part = {4'd0, mul_o, 4'd0};
        endcase
    end

    // mul_start rises one cycle after operands settle, drops on done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mul_start <= 1'b0;
        else       mul_start <= (state == REQ) && !got_fin;
    end

    // operand capture, nibble sequencing and partial-product sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abs_a <= 8'd0;
            abs_b <= 8'd0;
            sign  <= 1'b0;
            last  <= 1'b0;
            k     <= 2'd0;
            prod  <= 16'd0;
            mul_a <= 4'd0;
            mul_b <= 4'd0;
        end else begin
            if (accept) begin
                abs_a <= mag_a;
                abs_b <= mag_b;
                sign  <= in_a[7] ^ in_b[7];
                last  <= in_last;
                k     <= 2'd0;
                prod  <= 16'd0;
                mul_a <= mag_a[3:0];
                mul_b <= mag_b[3:0];
            end
            if (got_fin) prod <= prod + part;
            if (step) begin
                k     <= k_nx;
                mul_a <= k_nx[1] ? abs_a[7:4] : abs_a[3:0];
                mul_b <= k_nx[0] ? abs_b[7:4] : abs_b[3:0];
            end
        end
    end

    // signed product, extended to the accumulator width, and the sum
    always_comb begin
        p17  = {1'b0, prod};
        t17  = sign ? -p17 : p17;
        term = ACC_W'(t17);
        sum  = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
`ifdef VMAC_SAT_EN
        if (sum[ACC_W] != sum[ACC_W-1])
            acc_nx = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_nx = sum[ACC_W-1:0];
`else
        acc_nx = sum[ACC_W-1:0];
`endif
    end

    // accumulator: add in ACC, clear once the result is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              acc <= '0;
        else if (out_fire)      acc <= '0;
        else if (state == ACC)  acc <= acc_nx;
    end

endmodule
